// File: rtl/kernel_cpu_cpu_mult_ctrl_if.sv
// Request/response handshake bundle between a CPU pipeline and the 32x32 multiply sequencer.
// master = requester/consumer side, slave = the sequencer.
interface kernel_cpu_cpu_mult_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_hi;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;

  modport master (
    output req_valid, req_hi, req_src1, req_src2, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_hi, req_src1, req_src2, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/kernel_cpu_cpu_mult_ctrl.sv
// Sequencer for the 32x32 unsigned multiply built on the three-partial-product 16x16 cell.
// Define KERNEL_CPU_MULX_EN to add the hi*hi second pass that returns the upper product word (MULXUU).
module kernel_cpu_cpu_mult_ctrl #(
  parameter int CELL_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  kernel_cpu_cpu_mult_ctrl_if.slave i_bus,
  output logic [31:0]               o_cell_src1,
  output logic [31:0]               o_cell_src2,
  output logic                      o_cell_en,
  input  logic [31:0]               i_cell_p1,
  input  logic [31:0]               i_cell_p2,
  input  logic [31:0]               i_cell_p3
);

  localparam int CNT_W = $clog2(CELL_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CELL_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    MUL1,
    CAP1,
    MUL2,
    CAP2,
    RESP
  } state_t;

  state_t          r_state;
  state_t          w_stateNext;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]     r_src1;
  logic [31:0]     r_src2;
  logic [31:0]     r_rspData;
  logic            w_accept;
  logic            w_cntDone;
  logic            w_inMul;
  logic [32:0]     w_mid;
  logic [32:0]     w_sumLo;

  // Cross terms are summed at full width; only mid[15:0] lands in the low word.
  assign w_mid   = {1'b0, i_cell_p2} + {1'b0, i_cell_p3};
  assign w_sumLo = {1'b0, i_cell_p1} + {1'b0, w_mid[15:0], 16'h0};

`ifdef KERNEL_CPU_MULX_EN
  logic        r_reqHi;
  logic        r_carry;
  logic [16:0] r_midHi;
  logic [31:0] w_sumHi;

  assign w_sumHi = i_cell_p1 + {15'h0, r_midHi} + {31'h0, r_carry};
`else
  logic w_unused;

  assign w_unused = ^{i_bus.req_hi, w_mid[32:16], w_sumLo[32]};
`endif

  assign w_accept  = (r_state == IDLE) && i_bus.req_valid;
  assign w_inMul   = (r_state == MUL1) || (r_state == MUL2);
  assign w_cntDone = (r_cnt == CNT_LAST);

  assign i_bus.req_ready = (r_state == IDLE) && !reset;
  assign i_bus.rsp_valid = (r_state == RESP);
  assign i_bus.rsp_data  = r_rspData;
  assign o_cell_en       = w_inMul;
  assign o_cell_src1     = r_src1;
  assign o_cell_src2     = r_src2;

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: if (i_bus.req_valid) w_stateNext = MUL1;
      MUL1: if (w_cntDone) w_stateNext = CAP1;
`ifdef KERNEL_CPU_MULX_EN
      CAP1: w_stateNext = r_reqHi ? MUL2 : RESP;
      MUL2: if (w_cntDone) w_stateNext = CAP2;
      CAP2: w_stateNext = RESP;
`else
      CAP1: w_stateNext = RESP;
`endif
      RESP: if (i_bus.rsp_ready) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // The operand registers double as the cell drivers, so CAP1 reloads them with the high halves.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_src1    <= '0;
      r_src2    <= '0;
      r_rspData <= '0;
`ifdef KERNEL_CPU_MULX_EN
      r_reqHi   <= 1'b0;
      r_carry   <= 1'b0;
      r_midHi   <= '0;
`endif
    end else begin
      r_state <= w_stateNext;
      if (w_inMul) begin
        r_cnt <= w_cntDone ? '0 : r_cnt + 1'b1;
      end
      if (w_accept) begin
        r_src1 <= i_bus.req_src1;
        r_src2 <= i_bus.req_src2;
`ifdef KERNEL_CPU_MULX_EN
        r_reqHi <= i_bus.req_hi;
`endif
      end
      if (r_state == CAP1) begin
        r_rspData <= w_sumLo[31:0];
`ifdef KERNEL_CPU_MULX_EN
        r_carry <= w_sumLo[32];
        r_midHi <= w_mid[32:16];
        if (r_reqHi) begin
          r_src1 <= {16'h0, r_src1[31:16]};
          r_src2 <= {16'h0, r_src2[31:16]};
        end
`endif
      end
`ifdef KERNEL_CPU_MULX_EN
      if (r_state == CAP2) begin
        r_rspData <= w_sumHi;
      end
`endif
    end
  end

endmodule

// File: tb/tb_kernel_cpu_cpu_mult_ctrl.sv
// Scoreboard bench for kernel_cpu_cpu_mult_ctrl with a behavioural 16x16 three-partial-product cell.
// Expected words and response latencies follow KERNEL_CPU_MULX_EN when it is defined.
module tb_kernel_cpu_cpu_mult_ctrl;
  localparam int LAT = 1;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;

  typedef struct packed {
    logic [31:0] p1;
    logic [31:0] p2;
    logic [31:0] p3;
  } cell_t;

  logic        clk;
  logic        reset;
  logic [31:0] cellSrc1;
  logic [31:0] cellSrc2;
  logic        cellEn;
  logic [31:0] cellP1;
  logic [31:0] cellP2;
  logic [31:0] cellP3;
  cell_t       cellPipe [LAT];

  kernel_cpu_cpu_mult_ctrl_if bus ();

  kernel_cpu_cpu_mult_ctrl #(.CELL_LATENCY(LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_bus       (bus),
    .o_cell_src1 (cellSrc1),
    .o_cell_src2 (cellSrc2),
    .o_cell_en   (cellEn),
    .i_cell_p1   (cellP1),
    .i_cell_p2   (cellP2),
    .i_cell_p3   (cellP3)
  );

  exp_t sbQ [$];
  exp_t cur;
  int   nChecks = 0;
  int   miscompares = 0;
  int   edgeCount = 0;
  int   acceptEdge = 0;
  int   lastHsEdge = 0;
  int   stallLeft = 0;
  bit   inResp = 0;
  bit   checkQuick = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edgeCount <= edgeCount + 1;

  // Cell model: each enabled edge advances a LAT-deep pipeline of the three 16x16 products.
  always @(posedge clk) begin
    if (cellEn) begin
      cellPipe[0] <= {32'(cellSrc1[15:0]) * 32'(cellSrc2[15:0]),
                      32'(cellSrc1[15:0]) * 32'(cellSrc2[31:16]),
                      32'(cellSrc1[31:16]) * 32'(cellSrc2[15:0])};
      for (int i = 1; i < LAT; i++) cellPipe[i] <= cellPipe[i-1];
    end
  end
  assign cellP1 = cellPipe[LAT-1].p1;
  assign cellP2 = cellPipe[LAT-1].p2;
  assign cellP3 = cellPipe[LAT-1].p3;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic hi,
                               input logic [31:0] expLo, input logic [31:0] expHi, input bit push);
    exp_t e;
    int   waitCnt = 0;
    while (!bus.req_ready && waitCnt < 200) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    if (!bus.req_ready) begin
      checkOutput("req_ready_timeout", {31'h0, bus.req_ready}, 32'd1);
      return;
    end
    e.data = expLo;
    e.lat  = LAT + 2;
`ifdef KERNEL_CPU_MULX_EN
    if (hi) begin
      e.data = expHi;
      e.lat  = 2 * LAT + 3;
    end
`endif
    if (push) sbQ.push_back(e);
    bus.req_valid = 1'b1;
    bus.req_hi    = hi;
    bus.req_src1  = a;
    bus.req_src2  = b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_hi    = 1'b0;
    bus.req_src1  = '0;
    bus.req_src2  = '0;
  endtask

  task automatic waitIdle();
    int waitCnt = 0;
    while ((!bus.req_ready || inResp || sbQ.size() != 0) && waitCnt < 300) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    if (waitCnt >= 300) checkOutput("idle_timeout", {31'h0, bus.req_ready}, 32'd1);
  endtask

  // Consumer: asserts rsp_ready once stallLeft cycles of back-pressure have elapsed.
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.rsp_valid) begin
        if (stallLeft > 0) begin
          bus.rsp_ready = 1'b0;
          stallLeft--;
        end else begin
          bus.rsp_ready = 1'b1;
        end
      end else begin
        bus.rsp_ready = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on the first response cycle, then checks hold behaviour.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.req_valid && bus.req_ready) begin
        acceptEdge = edgeCount + 1;
        if (checkQuick) begin
          checkOutput("b2b_accept_edge", acceptEdge, lastHsEdge + 1);
          checkQuick = 0;
        end
      end
      if (bus.rsp_valid) begin
        if (!inResp) begin
          if (sbQ.size() == 0) begin
            checkOutput("spurious_rsp", {31'h0, bus.rsp_valid}, 32'd0);
          end else begin
            cur    = sbQ.pop_front();
            inResp = 1;
            checkOutput("rsp_data", bus.rsp_data, cur.data);
            checkOutput("rsp_latency", edgeCount - acceptEdge + 1, cur.lat);
            checkOutput("rsp_cell_en", {31'h0, cellEn}, 32'd0);
          end
        end else begin
          checkOutput("hold_data", bus.rsp_data, cur.data);
          checkOutput("hold_req_ready", {31'h0, bus.req_ready}, 32'd0);
          checkOutput("hold_cell_en", {31'h0, cellEn}, 32'd0);
        end
        if (bus.rsp_ready) begin
          inResp     = 0;
          lastHsEdge = edgeCount + 1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int waitCnt;
    int rstDelay;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_hi    = 1'b0;
    bus.req_src1  = '0;
    bus.req_src2  = '0;

    @(negedge clk);
    checkOutput("reset_req_ready", {31'h0, bus.req_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_req_ready", {31'h0, bus.req_ready}, 32'd1);
    checkOutput("post_reset_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
    checkOutput("post_reset_rsp_data", bus.rsp_data, 32'h0);
    checkOutput("post_reset_cell_en", {31'h0, cellEn}, 32'd0);
    checkOutput("post_reset_cell_src1", cellSrc1, 32'h0);
    checkOutput("post_reset_cell_src2", cellSrc2, 32'h0);
    @(posedge clk); #1;

    applyStimulus(32'h00010002, 32'h00030004, 1'b0, 32'h000A0008, 32'h00000003, 1'b1);
    applyStimulus(32'h00010002, 32'h00030004, 1'b1, 32'h000A0008, 32'h00000003, 1'b1);
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000001, 32'hFFFFFFFE, 1'b1);
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000001, 32'hFFFFFFFE, 1'b1);
    applyStimulus(32'h0000FFFF, 32'h0001FFFF, 1'b0, 32'hFFFD0001, 32'h00000001, 1'b1);
    applyStimulus(32'h0000FFFF, 32'h0001FFFF, 1'b1, 32'hFFFD0001, 32'h00000001, 1'b1);
    applyStimulus(32'h00018000, 32'h00018000, 1'b1, 32'h40000000, 32'h00000002, 1'b1);
    applyStimulus(32'h00000007, 32'h00000006, 1'b0, 32'h0000002A, 32'h00000000, 1'b1);
    applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    applyStimulus(32'h80000000, 32'h00000002, 1'b1, 32'h00000000, 32'h00000001, 1'b1);

    // Back-pressure for four cycles, then a request on the cycle after the handshake.
    waitIdle();
    stallLeft = 4;
    applyStimulus(32'h00010002, 32'h00030004, 1'b0, 32'h000A0008, 32'h00000003, 1'b1);
    checkQuick = 1;
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000001, 32'hFFFFFFFE, 1'b1);

    // Abort an in-flight request with reset (in MUL2 when the high pass exists).
    waitIdle();
`ifdef KERNEL_CPU_MULX_EN
    rstDelay = LAT + 1;
`else
    rstDelay = 0;
`endif
    applyStimulus(32'h12345678, 32'h9ABCDEF0, 1'b1, 32'h0, 32'h0, 1'b0);
    repeat (rstDelay) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
    checkOutput("abort_cell_en", {31'h0, cellEn}, 32'd0);
    checkOutput("abort_req_ready", {31'h0, bus.req_ready}, 32'd1);
    checkOutput("abort_rsp_data", bus.rsp_data, 32'h0);
    @(posedge clk); #1;
    applyStimulus(32'h0000FFFF, 32'h0001FFFF, 1'b1, 32'hFFFD0001, 32'h00000001, 1'b1);
    applyStimulus(32'h00010002, 32'h00030004, 1'b0, 32'h000A0008, 32'h00000003, 1'b1);

    waitCnt = 0;
    while ((sbQ.size() != 0 || inResp) && waitCnt < 500) begin
      @(posedge clk);
      waitCnt++;
    end
    if (sbQ.size() != 0 || inResp) checkOutput("drain_timeout", sbQ.size(), 32'd0);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, miscompares);
    $finish;
  end

endmodule
